operand_select_pipe: RTL

Parametrised, registered operand-B selector for the CPU execute stage: picks the ALU second operand from the register-file output, a sign- or zero-extended immediate, or one of several forwarded results. It optionally two's-complement negates the pick (SUB path) and holds it in a one-stage pipeline register. The register honours data-cache BUSYWAIT stalls and branch flushes. It replaces the fixed 8-bit register/immediate 2:1 selector between the register file and the ALU.

---
 rtl/operand_select_pipe.sv | 124 ++++++++++++
 1 files changed

// File: rtl/operand_select_pipe.sv
// operand_select_pipe
//
// Registered operand-B selector for the execute stage. Picks the ALU second
// operand from the register file, an extended immediate, or a forwarded
// result. Optionally negates the pick (two's complement, for the SUB path)
// and holds it in a one-stage pipeline register that honours stalls and
// flushes.
//
// Ports:
//   CLK            clock, all state updates on the rising edge
//   RESET          synchronous active-low reset
//   IN_VALID       an instruction presents an operand this cycle
//   STALL          freeze the stage (data-cache busywait)
//   FLUSH          kill the instruction entering the stage; beats STALL
//   SRC_SEL        0=REGOUT, 1=immediate, 2..NUM_FWD+1=FWD_DATA slot SRC_SEL-2
//   IMM_SIGNED     1: sign-extend the immediate, 0: zero-extend
//   NEG_SEL        1: output the two's complement of the selected value
//   REGOUT         register-file read data
//   IMMEDIATE_VAL  instruction immediate field
//   FWD_DATA       forwarded values, slot k at [k*DATA_WIDTH +: DATA_WIDTH]
//   OPERAND_OUT    registered operand to the ALU
//   OUT_VALID      OPERAND_OUT belongs to a live instruction
//   SEL_ERR        an out-of-range SRC_SEL was captured with a live instruction
//
// SEL_WIDTH is derived from NUM_FWD and must not be overridden.

module operand_select_pipe #(
  parameter int DATA_WIDTH = 8,
  parameter int IMM_WIDTH  = 8,
  parameter int NUM_FWD    = 2,
  parameter int SEL_WIDTH  = $clog2(NUM_FWD + 2)
) (
  input  logic                          CLK,
  input  logic                          RESET,
  input  logic                          IN_VALID,
  input  logic                          STALL,
  input  logic                          FLUSH,
  input  logic [SEL_WIDTH-1:0]          SRC_SEL,
  input  logic                          IMM_SIGNED,
  input  logic                          NEG_SEL,
  input  logic [DATA_WIDTH-1:0]         REGOUT,
  input  logic [IMM_WIDTH-1:0]          IMMEDIATE_VAL,
  input  logic [NUM_FWD*DATA_WIDTH-1:0] FWD_DATA,
  output logic [DATA_WIDTH-1:0]         OPERAND_OUT,
  output logic                          OUT_VALID,
  output logic                          SEL_ERR
);

  logic                  ext_fill;
  logic [DATA_WIDTH-1:0] imm_ext;
  logic [DATA_WIDTH-1:0] sel_val;
  logic                  sel_oor;
  logic [DATA_WIDTH-1:0] neg_val;
  int unsigned           sel_idx;

  logic [DATA_WIDTH-1:0] operand_d, operand_q;
  logic                  valid_d,   valid_q;
  logic                  err_d,     err_q;

  // Build fill bits above the immediate and keep only the low DATA_WIDTH bits;
  // when IMM_WIDTH == DATA_WIDTH the fill drops out entirely.
  always_comb begin
    ext_fill = IMM_SIGNED & IMMEDIATE_VAL[IMM_WIDTH-1];
    imm_ext  = DATA_WIDTH'({{DATA_WIDTH{ext_fill}}, IMMEDIATE_VAL});
  end

  // Source mux; out-of-range codes fall back to REGOUT and flag an error.
  always_comb begin
    sel_idx = 32'(SRC_SEL);
    sel_val = REGOUT;
    sel_oor = 1'b0;
    if (sel_idx == 1) begin
      sel_val = imm_ext;
    end
    for (int unsigned k = 0; k < NUM_FWD; k++) begin
      if (sel_idx == k + 2) begin
        sel_val = FWD_DATA[k*DATA_WIDTH +: DATA_WIDTH];
      end
    end
    if (sel_idx > NUM_FWD + 1) begin
      sel_oor = 1'b1;
    end
  end

  // Most-negative value wraps to itself; no overflow flag by design.
  always_comb begin
    neg_val = NEG_SEL ? (~sel_val + DATA_WIDTH'(1)) : sel_val;
  end

  // Next-state: flush beats stall, stall holds everything.
  always_comb begin
    operand_d = operand_q;
    valid_d   = valid_q;
    err_d     = err_q;
    if (FLUSH) begin
      operand_d = '0;
      valid_d   = 1'b0;
      err_d     = 1'b0;
    end else if (!STALL) begin
      operand_d = neg_val;
      valid_d   = IN_VALID;
      err_d     = IN_VALID & sel_oor;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      operand_q <= '0;
      valid_q   <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      operand_q <= operand_d;
      valid_q   <= valid_d;
      err_q     <= err_d;
    end
  end

  always_comb begin
    OPERAND_OUT = operand_q;
    OUT_VALID   = valid_q;
    SEL_ERR     = err_q;
  end

endmodule
